// File: rtl/lppm_pkg.sv
// Shared types and framing constants for the L-PPM frame transmitter.
package lppm_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SOF  = 3'd1,
        DATA = 3'd2,
        EOF  = 3'd3,
        GAP  = 3'd4
    } state_e;

    localparam int SOF_SLOTS   = 8;
    localparam int EOF_SLOTS   = 4;
    localparam int SOF_PULSE_A = 0;
    localparam int SOF_PULSE_B = 5;
    localparam int EOF_PULSE   = 2;

    // Guarded symbols put the pulse in the odd slot 2v+1 of a 2M-slot symbol.
    function automatic logic [4:0] pulse_slot(input logic [3:0] v, input logic guard);
        pulse_slot = guard ? {v, 1'b1} : {1'b0, v};
    endfunction

endpackage

// File: rtl/lppm_byte_fifo.sv
// Synchronous show-ahead FIFO holding {last, data} entries for the transmitter.
module lppm_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify requests against the registered occupancy.
    always_comb begin
        do_push_s = push && (count_q != FULL_CNT);
        do_pop_s  = pop && (count_q != '0);
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop_s)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/lppm_frame_tx.sv
// L-PPM frame transmitter: buffers bytes and emits SOF, payload symbols and EOF on an
// idle-high, active-low LED drive line.
module lppm_frame_tx #(
    parameter int BITS_PER_SYM = 2,
    parameter int SLOT_CYCLES  = 16,
    parameter int GUARD        = 1,
    parameter int FIFO_DEPTH   = 16,
    parameter int IFG_SLOTS    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       s_ready,
    output logic       dout,
    output logic       busy,
    output logic       err_underrun
);
    import lppm_pkg::*;

    localparam int M             = 1 << BITS_PER_SYM;
    localparam int SYM_SLOTS     = (GUARD != 0) ? 2 * M : M;
    localparam int SYMS_PER_BYTE = 8 / BITS_PER_SYM;
    localparam int CYC_W         = $clog2(SLOT_CYCLES);
    localparam int CNT_W         = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(SLOT_CYCLES - 1);
    localparam logic [3:0]       SYM_LAST = 4'(SYMS_PER_BYTE - 1);
    localparam logic [3:0]       SYM_MASK = 4'(M - 1);
    localparam logic [3:0]       B_W      = 4'(BITS_PER_SYM);

    state_e           state_q;
    logic [CYC_W-1:0] cyc_q;
    logic [5:0]       slot_q;
    logic [3:0]       sym_q;
    logic [7:0]       cur_byte_q;
    logic             cur_last_q;
    logic             dout_q;
    logic             err_underrun_q;
    logic [CNT_W-1:0] frames_pending_q;

    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic [8:0]       fifo_rdata_s;
    logic             push_s;
    logic             pop_s;
    logic             slot_end_s;
    logic             field_end_s;
    logic             pulse_s;
    logic [5:0]       last_slot_s;
    logic [3:0]       sym_val_s;

    lppm_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (9)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata ({s_last, s_data}),
        .rdata (fifo_rdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    assign s_ready = rst && (fifo_count_s != CNT_W'(FIFO_DEPTH));

    // Field length, pulse decision and pre-timed pop for the current cycle.
    always_comb begin
        last_slot_s = 6'd0;
        pulse_s     = 1'b0;
        sym_val_s   = 4'(cur_byte_q >> (sym_q * B_W)) & SYM_MASK;
        case (state_q)
            SOF: begin
                last_slot_s = 6'(SOF_SLOTS - 1);
                pulse_s     = (slot_q == 6'(SOF_PULSE_A)) || (slot_q == 6'(SOF_PULSE_B));
            end
            DATA: begin
                last_slot_s = 6'(SYM_SLOTS - 1);
                pulse_s     = (slot_q == {1'b0, pulse_slot(sym_val_s, GUARD != 0)});
            end
            EOF: begin
                last_slot_s = 6'(EOF_SLOTS - 1);
                pulse_s     = (slot_q == 6'(EOF_PULSE));
            end
            GAP: begin
                last_slot_s = 6'(IFG_SLOTS - 1);
                pulse_s     = 1'b0;
            end
            default: begin
                last_slot_s = 6'd0;
                pulse_s     = 1'b0;
            end
        endcase
        slot_end_s  = (cyc_q == CYC_LAST);
        field_end_s = slot_end_s && (slot_q == last_slot_s);
        pop_s       = !fifo_empty_s && field_end_s &&
                      ((state_q == SOF) ||
                       ((state_q == DATA) && (sym_q == SYM_LAST) && !cur_last_q));
        push_s      = s_valid && s_ready;
    end

    // Frame sequencer: state, slot timing, current byte and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            cyc_q          <= '0;
            slot_q         <= '0;
            sym_q          <= '0;
            cur_byte_q     <= 8'h00;
            cur_last_q     <= 1'b0;
            dout_q         <= 1'b1;
            err_underrun_q <= 1'b0;
        end else begin
            dout_q         <= !pulse_s;
            err_underrun_q <= 1'b0;
            cyc_q          <= slot_end_s ? '0 : cyc_q + 1'b1;
            slot_q         <= slot_end_s ? slot_q + 1'b1 : slot_q;
            case (state_q)
                IDLE: begin
                    cyc_q  <= '0;
                    slot_q <= '0;
                    sym_q  <= '0;
                    if ((frames_pending_q != '0) || fifo_full_s) state_q <= SOF;
                end
                SOF: begin
                    if (field_end_s) begin
                        state_q    <= DATA;
                        slot_q     <= '0;
                        sym_q      <= '0;
                        cur_byte_q <= fifo_rdata_s[7:0];
                        cur_last_q <= fifo_rdata_s[8];
                    end
                end
                DATA: begin
                    if (field_end_s) begin
                        slot_q <= '0;
                        if (sym_q != SYM_LAST) begin
                            sym_q <= sym_q + 1'b1;
                        end else if (cur_last_q) begin
                            sym_q   <= '0;
                            state_q <= EOF;
                        end else if (!fifo_empty_s) begin
                            sym_q      <= '0;
                            cur_byte_q <= fifo_rdata_s[7:0];
                            cur_last_q <= fifo_rdata_s[8];
                        end else begin
                            sym_q          <= '0;
                            state_q        <= EOF;
                            err_underrun_q <= 1'b1;
                        end
                    end
                end
                EOF: begin
                    if (field_end_s) begin
                        slot_q <= '0;
                        if (IFG_SLOTS > 0) state_q <= GAP;
                        else               state_q <= IDLE;
                    end
                end
                GAP: begin
                    if (field_end_s) begin
                        slot_q  <= '0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cyc_q   <= '0;
                    slot_q  <= '0;
                    sym_q   <= '0;
                end
            endcase
        end
    end

    // Complete frames held in the buffer, used to start transmission.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frames_pending_q <= '0;
        end else begin
            case ({push_s && s_last, pop_s && fifo_rdata_s[8]})
                2'b10:   frames_pending_q <= frames_pending_q + 1'b1;
                2'b01:   frames_pending_q <= frames_pending_q - 1'b1;
                default: frames_pending_q <= frames_pending_q;
            endcase
        end
    end

    assign dout         = dout_q;
    assign busy         = (state_q != IDLE);
    assign err_underrun = err_underrun_q;

endmodule
